// File: rtl/nn_bias_layer_sequencer.sv
// nn_bias_layer_sequencer: runs one hidden- or output-layer pass per start edge.
// Adds a per-neuron bias to each MAC accumulator and saturates the sum.
// Streams the result with valid/ready and tracks argmax on the output layer.
// Optional feature macro: NN_SEQ_RELU_EN, which clamps negative hidden-layer results to 0.
module nn_bias_layer_sequencer #(
    parameter int DATA_W     = 32,
    parameter int NUM_HIDDEN = 8,
    parameter int NUM_OUT    = 10
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic [31:0]                          control,
    input  logic [(NUM_HIDDEN+NUM_OUT)*32-1:0]   bias_flat,
    input  logic [DATA_W-1:0]                    s_acc_data,
    input  logic                                 s_acc_last,
    input  logic                                 s_acc_valid,
    output logic                                 s_acc_ready,
    output logic [DATA_W-1:0]                    m_res_data,
    output logic                                 m_res_last,
    output logic                                 m_res_valid,
    input  logic                                 m_res_ready,
    output logic [31:0]                          status
);

    localparam logic [7:0] N_HID = 8'(NUM_HIDDEN);
    localparam logic [7:0] N_OUT = 8'(NUM_OUT);
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state;
    state_t                     next_state;
    logic                       start_prev;
    logic                       start_edge;
    logic                       abort_req;
    logic                       layer;
    logic [7:0]                 count;
    logic [15:0]                cycles;
    logic [3:0]                 argmax;
    logic signed [DATA_W-1:0]   best;
    logic                       last_err;
    logic                       aborted;
    logic [7:0]                 beats_n;
    logic [7:0]                 bias_idx;
    logic [31:0]                bias_word;
    logic [DATA_W-1:0]          bias;
    logic signed [DATA_W:0]     sum;
    logic signed [DATA_W-1:0]   sat;
    logic signed [DATA_W-1:0]   result;
    logic                       out_free;
    logic                       acc_fire;
    logic                       is_final;
    logic                       unused_control;

    assign unused_control = ^control[31:3];

    assign start_edge = control[0] & ~start_prev;
    assign abort_req  = control[1];
    assign beats_n    = layer ? N_OUT : N_HID;
    assign bias_idx   = layer ? (count + N_HID) : count;
    assign bias_word  = bias_flat[32*bias_idx +: 32];
    assign bias       = bias_word[DATA_W-1:0];
    assign sum        = $signed({s_acc_data[DATA_W-1], s_acc_data}) + $signed({bias[DATA_W-1], bias});
    assign out_free   = !m_res_valid || m_res_ready;
    assign s_acc_ready = (state == RUN) && (count < beats_n) && out_free;
    assign acc_fire   = s_acc_valid && s_acc_ready;
    assign is_final   = (count == beats_n - 8'd1);

    assign status = {cycles, count, argmax, aborted, last_err, (state == DONE), (state == RUN)};

    // Saturate the widened sum, then optionally clamp hidden-layer negatives
    always_comb begin
        sat = sum[DATA_W-1:0];
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            sat = sum[DATA_W] ? SAT_MIN : SAT_MAX;
        end
        result = sat;
`ifdef NN_SEQ_RELU_EN
        if (!layer && sat[DATA_W-1]) begin
            result = '0;
        end
`endif
    end

    // Previous start level for rising-edge detection
    always_ff @(posedge aclk) begin
        if (areset) begin
            start_prev <= 1'b0;
        end else begin
            start_prev <= control[0];
        end
    end

    // FSM state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state: finish only once the last result has left the output register
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_edge) next_state = RUN;
            end
            RUN: begin
                if (abort_req) begin
                    next_state = IDLE;
                end else if ((count == beats_n) && out_free) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start_edge) next_state = RUN;
            end
            default: next_state = IDLE;
        endcase
    end

    // Pass bookkeeping, result register and argmax tracking
    always_ff @(posedge aclk) begin
        if (areset) begin
            layer       <= 1'b0;
            count       <= '0;
            cycles      <= '0;
            argmax      <= '0;
            best        <= '0;
            last_err    <= 1'b0;
            aborted     <= 1'b0;
            m_res_data  <= '0;
            m_res_last  <= 1'b0;
            m_res_valid <= 1'b0;
        end else if (state != RUN && start_edge) begin
            layer       <= control[2];
            count       <= '0;
            cycles      <= '0;
            argmax      <= '0;
            best        <= '0;
            last_err    <= 1'b0;
            aborted     <= 1'b0;
            m_res_last  <= 1'b0;
            m_res_valid <= 1'b0;
        end else if (state == RUN) begin
            if (cycles != 16'hFFFF) begin
                cycles <= cycles + 16'd1;
            end
            if (abort_req) begin
                aborted     <= 1'b1;
                m_res_valid <= 1'b0;
                m_res_last  <= 1'b0;
            end else if (acc_fire) begin
                m_res_data  <= result;
                m_res_valid <= 1'b1;
                m_res_last  <= is_final;
                count       <= count + 8'd1;
                if (s_acc_last != is_final) begin
                    last_err <= 1'b1;
                end
                if (layer && ((count == 8'd0) || (result > best))) begin
                    best   <= result;
                    argmax <= count[3:0];
                end
            end else if (m_res_ready) begin
                m_res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nn_bias_layer_sequencer.sv
// Scoreboard bench for nn_bias_layer_sequencer: stimulus pushes hand-computed
// expected results; a negedge monitor pops and compares every output transfer.
module tb_nn_bias_layer_sequencer;

    logic         aclk = 1'b0;
    logic         areset;
    logic [31:0]  control;
    logic [575:0] bias_flat;
    logic [31:0]  s_acc_data;
    logic         s_acc_last;
    logic         s_acc_valid;
    logic         s_acc_ready;
    logic [31:0]  m_res_data;
    logic         m_res_last;
    logic         m_res_valid;
    logic         m_res_ready;
    logic [31:0]  status;

    int n_pass  = 0;
    int n_total = 0;
    bit bp_en   = 1'b0;

    logic [31:0] exp_q[$];
    logic        last_q[$];
    logic [31:0] vec_acc[10];
    logic [31:0] vec_exp[10];

    nn_bias_layer_sequencer #(.DATA_W(32), .NUM_HIDDEN(8), .NUM_OUT(10)) dut (
        .aclk(aclk), .areset(areset), .control(control), .bias_flat(bias_flat),
        .s_acc_data(s_acc_data), .s_acc_last(s_acc_last), .s_acc_valid(s_acc_valid),
        .s_acc_ready(s_acc_ready), .m_res_data(m_res_data), .m_res_last(m_res_last),
        .m_res_valid(m_res_valid), .m_res_ready(m_res_ready), .status(status)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_bias(input int k, input logic [31:0] v);
        bias_flat[32*k +: 32] = v;
    endtask

    // Monitor: scoreboard compare, stall stability, input ready during stalls
    initial begin
        logic        stall_prev = 1'b0;
        logic [31:0] held_data  = '0;
        logic        held_last  = 1'b0;
        logic [31:0] e;
        logic        el;
        forever begin
            @(negedge aclk);
            if (!areset) begin
                if (stall_prev) begin
                    check("stall_valid_held", {31'd0, m_res_valid}, 32'd1);
                    check("stall_data_held", m_res_data, held_data);
                    check("stall_last_held", {31'd0, m_res_last}, {31'd0, held_last});
                end
                if (m_res_valid && !m_res_ready) begin
                    check("s_acc_ready_in_stall", {31'd0, s_acc_ready}, 32'd0);
                end
                if (m_res_valid && m_res_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_beat: got %0h with no expected beat queued", m_res_data);
                    end else begin
                        e  = exp_q.pop_front();
                        el = last_q.pop_front();
                        check("res_data", m_res_data, e);
                        check("res_last", {31'd0, m_res_last}, {31'd0, el});
                    end
                end
                stall_prev = m_res_valid && !m_res_ready;
                held_data  = m_res_data;
                held_last  = m_res_last;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Downstream backpressure: toggle ready each cycle while enabled
    initial begin
        forever begin
            @(posedge aclk);
            #2;
            if (bp_en) m_res_ready = ~m_res_ready;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [31:0] acc, input logic last, input logic [31:0] exp, input logic exp_last);
        int t;
        s_acc_data  = acc;
        s_acc_last  = last;
        s_acc_valid = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!s_acc_ready && t < 200) begin
            t++;
            @(negedge aclk);
        end
        check("accept_wait", {31'd0, s_acc_ready}, 32'd1);
        if (s_acc_ready) begin
            exp_q.push_back(exp);
            last_q.push_back(exp_last);
        end
        @(posedge aclk);
        #1;
        s_acc_valid = 1'b0;
        s_acc_last  = 1'b0;
    endtask

    task automatic start_pass(input logic lay);
        @(posedge aclk);
        #1;
        control    = '0;
        control[2] = lay;
        control[0] = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic finish_pass();
        int t;
        t = 0;
        @(negedge aclk);
        while (!status[1] && t < 200) begin
            t++;
            @(negedge aclk);
        end
        check("done_reached", {31'd0, status[1]}, 32'd1);
        check("busy_after_done", {31'd0, status[0]}, 32'd0);
        repeat (3) @(negedge aclk);
        check("held_start_no_retrigger", {31'd0, status[1]}, 32'd1);
        @(posedge aclk);
        #1;
        control[0] = 1'b0;
    endtask

    task automatic run_pass(input logic lay, input int n, input int last_at);
        start_pass(lay);
        for (int i = 0; i < n; i++) begin
            send(vec_acc[i], (i == last_at), vec_exp[i], (i == n - 1));
        end
        finish_pass();
    endtask

    initial begin
        areset      = 1'b1;
        control     = '0;
        bias_flat   = '0;
        s_acc_data  = '0;
        s_acc_last  = 1'b0;
        s_acc_valid = 1'b0;
        m_res_ready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("rst_s_acc_ready", {31'd0, s_acc_ready}, 32'd0);
        check("rst_m_res_valid", {31'd0, m_res_valid}, 32'd0);
        check("rst_m_res_data", m_res_data, 32'd0);
        check("rst_m_res_last", {31'd0, m_res_last}, 32'd0);
        check("rst_status", status, 32'd0);

        // Hidden pass: bias 10, acc -5,1..7
        for (int k = 0; k < 8; k++) set_bias(k, 32'd10);
        vec_acc[0] = -32'sd5;
        vec_exp[0] = 32'd5;
        for (int i = 1; i < 8; i++) begin
            vec_acc[i] = 32'(i);
            vec_exp[i] = 32'(i + 10);
        end
        run_pass(1'b0, 8, 7);
        check("hid_count", {24'd0, status[15:8]}, 32'd8);
        check("hid_last_err", {31'd0, status[2]}, 32'd0);
        check("hid_argmax", {28'd0, status[7:4]}, 32'd0);

        // Output layer argmax with tie
        for (int k = 8; k < 18; k++) set_bias(k, 32'd0);
        vec_acc[0] = 32'd0; vec_acc[1] = 32'd3; vec_acc[2] = 32'd9; vec_acc[3] = 32'd9;
        vec_acc[4] = 32'd1; vec_acc[5] = 32'd0; vec_acc[6] = 32'd0; vec_acc[7] = 32'd0;
        vec_acc[8] = 32'd0; vec_acc[9] = 32'd2;
        for (int i = 0; i < 10; i++) vec_exp[i] = vec_acc[i];
        run_pass(1'b1, 10, 9);
        check("out_argmax_tie", {28'd0, status[7:4]}, 32'd2);
        check("out_count", {24'd0, status[15:8]}, 32'd10);
        check("out_last_err", {31'd0, status[2]}, 32'd0);

        // Saturation on output layer (never ReLU'd)
        set_bias(8, 32'h7FFFFFF0);
        set_bias(9, 32'h80000010);
        vec_acc[0] = 32'h00000100; vec_exp[0] = 32'h7FFFFFFF;
        vec_acc[1] = -32'sh100;    vec_exp[1] = 32'h80000000;
        for (int i = 2; i < 10; i++) begin
            vec_acc[i] = 32'd0;
            vec_exp[i] = 32'd0;
        end
        run_pass(1'b1, 10, 9);
        check("sat_argmax", {28'd0, status[7:4]}, 32'd0);

        // Backpressure with early last flag (beat 7 instead of 8)
        for (int i = 0; i < 8; i++) begin
            vec_acc[i] = 32'(100 + i);
            vec_exp[i] = 32'(110 + i);
        end
        bp_en = 1'b1;
        run_pass(1'b0, 8, 6);
        bp_en = 1'b0;
        m_res_ready = 1'b1;
        check("bp_count", {24'd0, status[15:8]}, 32'd8);
        check("bp_last_err", {31'd0, status[2]}, 32'd1);

        // Abort after the fourth beat
        start_pass(1'b0);
        for (int i = 0; i < 4; i++) send(32'(i), 1'b0, 32'(i + 10), 1'b0);
        control[1] = 1'b1;
        @(posedge aclk);
        #1;
        control[1] = 1'b0;
        @(negedge aclk);
        check("abort_busy", {31'd0, status[0]}, 32'd0);
        check("abort_flag", {31'd0, status[3]}, 32'd1);
        check("abort_done", {31'd0, status[1]}, 32'd0);
        check("abort_valid", {31'd0, m_res_valid}, 32'd0);
        check("abort_s_ready", {31'd0, s_acc_ready}, 32'd0);
        @(posedge aclk);
        #1;
        control[0] = 1'b0;

        // Clean pass after abort
        for (int i = 0; i < 8; i++) begin
            vec_acc[i] = 32'(i + 1);
            vec_exp[i] = 32'(i + 11);
        end
        run_pass(1'b0, 8, 7);
        check("post_abort_flag", {31'd0, status[3]}, 32'd0);
        check("post_abort_count", {24'd0, status[15:8]}, 32'd8);

        // ReLU: hidden -20 + 5
        set_bias(0, 32'd5);
        vec_acc[0] = -32'sd20;
`ifdef NN_SEQ_RELU_EN
        vec_exp[0] = 32'd0;
`else
        vec_exp[0] = -32'sd15;
`endif
        for (int i = 1; i < 8; i++) begin
            vec_acc[i] = 32'd0;
            vec_exp[i] = 32'd10;
        end
        run_pass(1'b0, 8, 7);

        // Output layer same values: never ReLU'd
        set_bias(8, 32'd5);
        set_bias(9, 32'd0);
        vec_acc[0] = -32'sd20;
        vec_exp[0] = -32'sd15;
        for (int i = 1; i < 10; i++) begin
            vec_acc[i] = 32'd0;
            vec_exp[i] = 32'd0;
        end
        run_pass(1'b1, 10, 9);
        check("relu_out_argmax", {28'd0, status[7:4]}, 32'd1);

        repeat (3) @(negedge aclk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
